mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Fetch/data request ports and the single-port RAM port shared by mem_arbiter.
// slave = arbiter side; master = pipeline stages plus RAM side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        cancel;

  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, cancel, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, cancel, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between fetch (IF) and data (MEM); MEM wins unless FAIR_ARB_EN starvation guard fires.
// Latency: grants/RAM drive combinational, read data 1 cycle after grant; writes complete in the grant cycle.
// Backpressure: no queueing -- a refused requester holds its request stable until its gnt is seen.
module mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_MEM} state_t;

  state_t      state, state_nxt;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        force_if;
  logic        if_gnt, mem_gnt;
  logic        if_rvalid, mem_rvalid;

`ifdef FAIR_ARB_EN
  localparam int CNT_W = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // Counts consecutive refusals of a pending fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_if = (starve_cnt == CNT_MAX) && bus.if_req && bus.mem_req;
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^(32'(STARVE_MAX));
  assign force_if = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:10], bus.if_addr[1:0],
                              bus.mem_addr[31:10], bus.mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (if_rvalid)  if_rdata_q  <= bus.ram_rdata;
      if (mem_rvalid) mem_rdata_q <= bus.ram_rdata;
    end
  end

  always_comb begin
    state_nxt     = IDLE;
    if_gnt        = 1'b0;
    mem_gnt       = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_wen   = 4'h0;
    bus.ram_addr  = 8'h00;
    bus.ram_wdata = 32'h0;

    if (resetn) begin
      if (bus.mem_req && !force_if) begin
        mem_gnt       = 1'b1;
        bus.ram_en    = 1'b1;
        bus.ram_wen   = bus.mem_wen;
        bus.ram_addr  = bus.mem_addr[9:2];
        bus.ram_wdata = bus.mem_wdata;
        state_nxt     = (bus.mem_wen == 4'h0) ? RD_MEM : IDLE;
      end else if (bus.if_req) begin
        if_gnt       = 1'b1;
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.if_addr[9:2];
        // A flush in the grant cycle kills the fetch before its data returns.
        state_nxt    = bus.cancel ? IDLE : RD_IF;
      end
    end

    // The state register names the owner of last cycle's read; cancel only masks fetch data.
    if_rvalid  = (state == RD_IF) && !bus.cancel;
    mem_rvalid = (state == RD_MEM);
  end

  assign bus.if_gnt     = if_gnt;
  assign bus.mem_gnt    = mem_gnt;
  assign bus.if_rvalid  = if_rvalid;
  assign bus.mem_rvalid = mem_rvalid;
  assign bus.if_rdata   = if_rvalid  ? bus.ram_rdata : if_rdata_q;
  assign bus.mem_rdata  = mem_rvalid ? bus.ram_rdata : mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM; RAM word i preloads to 0xC0DE_0000 | i.
// Expected arbitration patterns follow FAIR_ARB_EN when the bench is built with that macro.
module tb_mem_arbiter;

`ifdef FAIR_ARB_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] ram [256];

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      if (bus.ram_wen == 4'h0) bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_wen = 4'h0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    bus.cancel = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.if_req = 1'b1; bus.mem_req = 1'b1; bus.if_addr = 32'h10; bus.mem_addr = 32'h20;
    next_cycle(); #2;
    n_vec++; if (bus.if_gnt !== 1'b0)  begin n_err++; $display("FAIL rst_if_gnt got=%b exp=0", bus.if_gnt); end
    n_vec++; if (bus.mem_gnt !== 1'b0) begin n_err++; $display("FAIL rst_mem_gnt got=%b exp=0", bus.mem_gnt); end
    n_vec++; if (bus.ram_en !== 1'b0)  begin n_err++; $display("FAIL rst_ram_en got=%b exp=0", bus.ram_en); end
    next_cycle(); #2;
    n_vec++; if (bus.if_rvalid !== 1'b0)  begin n_err++; $display("FAIL rst_if_rvalid got=%b exp=0", bus.if_rvalid); end
    n_vec++; if (bus.mem_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mem_rvalid got=%b exp=0", bus.mem_rvalid); end
    n_vec++; if (bus.if_rdata !== 32'h0)  begin n_err++; $display("FAIL rst_if_rdata got=%h exp=0", bus.if_rdata); end
    n_vec++; if (bus.mem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_rdata got=%h exp=0", bus.mem_rdata); end
    idle_inputs();
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_if_read();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010; #2;
    n_vec++; if (bus.if_gnt !== 1'b1)    begin n_err++; $display("FAIL ifrd_gnt got=%b exp=1", bus.if_gnt); end
    n_vec++; if (bus.mem_gnt !== 1'b0)   begin n_err++; $display("FAIL ifrd_mem_gnt got=%b exp=0", bus.mem_gnt); end
    n_vec++; if (bus.ram_en !== 1'b1)    begin n_err++; $display("FAIL ifrd_ram_en got=%b exp=1", bus.ram_en); end
    n_vec++; if (bus.ram_addr !== 8'h04) begin n_err++; $display("FAIL ifrd_ram_addr got=%h exp=04", bus.ram_addr); end
    n_vec++; if (bus.ram_wen !== 4'h0)   begin n_err++; $display("FAIL ifrd_ram_wen got=%h exp=0", bus.ram_wen); end
    next_cycle();
    bus.if_req = 1'b0; #2;
    n_vec++; if (bus.if_rvalid !== 1'b1)       begin n_err++; $display("FAIL ifrd_rvalid got=%b exp=1", bus.if_rvalid); end
    n_vec++; if (bus.if_rdata !== 32'hC0DE0004) begin n_err++; $display("FAIL ifrd_rdata got=%h exp=C0DE0004", bus.if_rdata); end
    n_vec++; if (bus.mem_rvalid !== 1'b0)      begin n_err++; $display("FAIL ifrd_mem_rvalid got=%b exp=0", bus.mem_rvalid); end
    next_cycle(); #2;
    n_vec++; if (bus.if_rvalid !== 1'b0)       begin n_err++; $display("FAIL ifrd_rvalid_drop got=%b exp=0", bus.if_rvalid); end
    n_vec++; if (bus.if_rdata !== 32'hC0DE0004) begin n_err++; $display("FAIL ifrd_rdata_hold got=%h exp=C0DE0004", bus.if_rdata); end
  endtask

  task automatic test_mem_write();
    next_cycle();
    bus.mem_req = 1'b1; bus.mem_wen = 4'hF; bus.mem_addr = 32'h20; bus.mem_wdata = 32'hDEADBEEF;
    bus.if_req = 1'b1; bus.if_addr = 32'h30; #2;
    n_vec++; if (bus.mem_gnt !== 1'b1)          begin n_err++; $display("FAIL wr_mem_gnt got=%b exp=1", bus.mem_gnt); end
    n_vec++; if (bus.if_gnt !== 1'b0)           begin n_err++; $display("FAIL wr_if_gnt got=%b exp=0", bus.if_gnt); end
    n_vec++; if (bus.ram_wen !== 4'hF)          begin n_err++; $display("FAIL wr_ram_wen got=%h exp=F", bus.ram_wen); end
    n_vec++; if (bus.ram_addr !== 8'h08)        begin n_err++; $display("FAIL wr_ram_addr got=%h exp=08", bus.ram_addr); end
    n_vec++; if (bus.ram_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_ram_wdata got=%h exp=DEADBEEF", bus.ram_wdata); end
    next_cycle();
    bus.if_req = 1'b0; bus.mem_wen = 4'b0011; bus.mem_addr = 32'h24; bus.mem_wdata = 32'h12345678; #2;
    n_vec++; if (bus.mem_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid got=%b exp=0", bus.mem_rvalid); end
    n_vec++; if (bus.if_rvalid !== 1'b0)  begin n_err++; $display("FAIL wr_no_if_rvalid got=%b exp=0", bus.if_rvalid); end
    n_vec++; if (bus.ram_wen !== 4'h3)    begin n_err++; $display("FAIL wr_part_wen got=%h exp=3", bus.ram_wen); end
    next_cycle();
    bus.mem_wen = 4'h0; bus.mem_addr = 32'h20; #2;
    n_vec++; if (bus.mem_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_part_no_rvalid got=%b exp=0", bus.mem_rvalid); end
    n_vec++; if (bus.mem_gnt !== 1'b1)    begin n_err++; $display("FAIL rd_mem_gnt got=%b exp=1", bus.mem_gnt); end
    next_cycle();
    bus.mem_addr = 32'h24; #2;
    n_vec++; if (bus.mem_rvalid !== 1'b1)        begin n_err++; $display("FAIL rd_mem_rvalid got=%b exp=1", bus.mem_rvalid); end
    n_vec++; if (bus.mem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_mem_rdata got=%h exp=DEADBEEF", bus.mem_rdata); end
    next_cycle();
    idle_inputs(); #2;
    n_vec++; if (bus.mem_rvalid !== 1'b1)        begin n_err++; $display("FAIL rd_part_rvalid got=%b exp=1", bus.mem_rvalid); end
    n_vec++; if (bus.mem_rdata !== 32'hC0DE5678) begin n_err++; $display("FAIL rd_part_rdata got=%h exp=C0DE5678", bus.mem_rdata); end
  endtask

  task automatic test_arbitration();
    logic prev_if = 1'b0;
    logic prev_mem = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic exp_if;
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.mem_req = 1'b1; bus.mem_wen = 4'h0; bus.mem_addr = 32'h44; #2;
      exp_if = FAIR && (k % 4 == 3);
      n_vec++; if (bus.if_gnt !== exp_if)   begin n_err++; $display("FAIL arb_if_gnt[%0d] got=%b exp=%b", k, bus.if_gnt, exp_if); end
      n_vec++; if (bus.mem_gnt !== !exp_if) begin n_err++; $display("FAIL arb_mem_gnt[%0d] got=%b exp=%b", k, bus.mem_gnt, !exp_if); end
      n_vec++; if (bus.if_rvalid !== prev_if)   begin n_err++; $display("FAIL arb_if_rvalid[%0d] got=%b exp=%b", k, bus.if_rvalid, prev_if); end
      n_vec++; if (bus.mem_rvalid !== prev_mem) begin n_err++; $display("FAIL arb_mem_rvalid[%0d] got=%b exp=%b", k, bus.mem_rvalid, prev_mem); end
      prev_if = exp_if;
      prev_mem = !exp_if;
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_cancel();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h14; #2;
    n_vec++; if (bus.if_gnt !== 1'b1) begin n_err++; $display("FAIL cxl_if_gnt got=%b exp=1", bus.if_gnt); end
    next_cycle();
    bus.if_req = 1'b0; bus.cancel = 1'b1;
    bus.mem_req = 1'b1; bus.mem_wen = 4'h0; bus.mem_addr = 32'h18; #2;
    n_vec++; if (bus.if_rvalid !== 1'b0) begin n_err++; $display("FAIL cxl_if_rvalid got=%b exp=0", bus.if_rvalid); end
    n_vec++; if (bus.mem_gnt !== 1'b1)   begin n_err++; $display("FAIL cxl_mem_gnt got=%b exp=1", bus.mem_gnt); end
    next_cycle();
    idle_inputs(); #2;
    n_vec++; if (bus.mem_rvalid !== 1'b1)        begin n_err++; $display("FAIL cxl_mem_rvalid got=%b exp=1", bus.mem_rvalid); end
    n_vec++; if (bus.mem_rdata !== 32'hC0DE0006) begin n_err++; $display("FAIL cxl_mem_rdata got=%h exp=C0DE0006", bus.mem_rdata); end
    n_vec++; if (bus.if_rvalid !== 1'b0)         begin n_err++; $display("FAIL cxl_if_rvalid2 got=%b exp=0", bus.if_rvalid); end
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h1C; bus.cancel = 1'b1; #2;
    n_vec++; if (bus.if_gnt !== 1'b1) begin n_err++; $display("FAIL cxlg_if_gnt got=%b exp=1", bus.if_gnt); end
    next_cycle();
    idle_inputs(); #2;
    n_vec++; if (bus.if_rvalid !== 1'b0) begin n_err++; $display("FAIL cxlg_if_rvalid got=%b exp=0", bus.if_rvalid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      next_cycle();
      idle_inputs();
      if (i < 8) begin
        if (i % 2 == 0) begin bus.if_req = 1'b1; bus.if_addr = 32'h80 + 32'(4 * i); end
        else begin bus.mem_req = 1'b1; bus.mem_addr = 32'h80 + 32'(4 * i); end
      end
      #2;
      if (i < 8) begin
        n_vec++; if (bus.if_gnt !== (i % 2 == 0)) begin n_err++; $display("FAIL b2b_if_gnt[%0d] got=%b", i, bus.if_gnt); end
        n_vec++; if (bus.mem_gnt !== (i % 2 == 1)) begin n_err++; $display("FAIL b2b_mem_gnt[%0d] got=%b", i, bus.mem_gnt); end
      end
      if (i > 0) begin
        logic        was_if;
        logic [31:0] got, exp_d;
        was_if = ((i - 1) % 2 == 0);
        got = was_if ? bus.if_rdata : bus.mem_rdata;
        exp_d = 32'hC0DE0020 + 32'(i - 1);
        n_vec++; if (bus.if_rvalid !== was_if)   begin n_err++; $display("FAIL b2b_if_rvalid[%0d] got=%b exp=%b", i, bus.if_rvalid, was_if); end
        n_vec++; if (bus.mem_rvalid !== !was_if) begin n_err++; $display("FAIL b2b_mem_rvalid[%0d] got=%b exp=%b", i, bus.mem_rvalid, !was_if); end
        n_vec++; if (got !== exp_d) begin n_err++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, got, exp_d); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h50; bus.mem_req = 1'b1; bus.mem_wen = 4'h0; bus.mem_addr = 32'h54;
    end
    next_cycle();
    resetn = 1'b0; #2;
    n_vec++; if (bus.if_gnt !== 1'b0)  begin n_err++; $display("FAIL mrst_if_gnt got=%b exp=0", bus.if_gnt); end
    n_vec++; if (bus.mem_gnt !== 1'b0) begin n_err++; $display("FAIL mrst_mem_gnt got=%b exp=0", bus.mem_gnt); end
    n_vec++; if (bus.ram_en !== 1'b0)  begin n_err++; $display("FAIL mrst_ram_en got=%b exp=0", bus.ram_en); end
    for (int k = 0; k < 4; k++) begin
      logic exp_if;
      next_cycle();
      resetn = 1'b1; #2;
      if (k == 0) begin
        n_vec++; if (bus.mem_rvalid !== 1'b0) begin n_err++; $display("FAIL mrst_mem_rvalid got=%b exp=0", bus.mem_rvalid); end
        n_vec++; if (bus.if_rvalid !== 1'b0)  begin n_err++; $display("FAIL mrst_if_rvalid got=%b exp=0", bus.if_rvalid); end
        n_vec++; if (bus.mem_rdata !== 32'h0) begin n_err++; $display("FAIL mrst_mem_rdata got=%h exp=0", bus.mem_rdata); end
      end
      exp_if = FAIR && (k == 3);
      n_vec++; if (bus.if_gnt !== exp_if) begin n_err++; $display("FAIL mrst_cnt_if_gnt[%0d] got=%b exp=%b", k, bus.if_gnt, exp_if); end
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
    idle_inputs();
    resetn = 1'b0;
    test_reset();
    test_if_read();
    test_mem_write();
    test_arbitration();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
